// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout, TX engine states and the bus window base.
package mmio_pkg;

   // Base of the UART window; consumed by the external CE decode.
   localparam logic [31:0] MMIO_BASE = 32'h0020_0000;

   // Register select is ADDR[3:2] of the byte address (word index in the window).
   localparam int unsigned REG_SEL_W   = 2;
   localparam logic [1:0]  REG_TXDATA  = 2'd0;  // byte offset 0x0
   localparam logic [1:0]  REG_STATUS  = 2'd1;  // byte offset 0x4
   localparam logic [1:0]  REG_BAUDDIV = 2'd2;  // byte offset 0x8
   localparam logic [1:0]  REG_IRQEN   = 2'd3;  // byte offset 0xC

   // STATUS bit positions.
   localparam int unsigned ST_FULL      = 0;
   localparam int unsigned ST_EMPTY     = 1;
   localparam int unsigned ST_BUSY      = 2;
   localparam int unsigned ST_OVF       = 3;
   localparam int unsigned ST_COUNT_LSB = 8;
   localparam int unsigned ST_COUNT_W   = 8;

   localparam int unsigned BAUD_W = 16;
   localparam int unsigned BYTE_W = 8;

   // TX engine states.
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // STATUS read payload; field order matches the bit positions above.
   typedef struct packed {
      logic [15:0]           rsvd_hi;
      logic [ST_COUNT_W-1:0] count;
      logic [3:0]            rsvd_lo;
      logic                  ovf;
      logic                  busy;
      logic                  empty;
      logic                  full;
   } status_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push is judged against
// the occupancy before any same-cycle pop, so a full FIFO always drops.
module uart_tx_fifo
   import mmio_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              full_q;
   logic              empty_q;
   logic              push_ok;
   logic              pop_ok;

   // Qualify requests against current occupancy and form the next count.
   always_comb begin
      push_ok = push_i & ~full_q;
      pop_ok  = pop_i & ~empty_q;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage array; contents need no reset since occupancy guards reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Optional feature macro: MMIO_UART_IRQ_EN adds the IRQ output and the
// IRQEN register at offset 0xC; without it 0xC reads 0 and ignores writes.
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic [29:0] ADDR,
   input  logic [31:0] DATAI,
   input  logic [3:0]  WSTB,
   output logic [31:0] DATAO,
   output logic        TXD
`ifdef MMIO_UART_IRQ_EN
   ,
   output logic        IRQ
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Bus decode
   logic                 rd_en;
   logic                 wr_en;
   logic [REG_SEL_W-1:0] reg_sel;
   logic                 push_req;
   logic                 ovf_clr;
   logic                 baud_wr;

   // Registers
   logic [31:0]       datao_q;
   logic              ovf_q;
   logic [BAUD_W-1:0] baud_q;
`ifdef MMIO_UART_IRQ_EN
   logic              irqen_q;
   logic              irq_q;
`endif

   // FIFO
   logic              fifo_pop;
   logic [BYTE_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   // TX engine
   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d;
   logic [BAUD_W-1:0] div_q, div_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [BYTE_W-1:0] shreg_q, shreg_d;
   logic              txd_q, txd_d;

   // Read mux
   status_t           status_c;
   logic [31:0]       rdata_c;

   logic              unused_ok;
   assign unused_ok = ^{ADDR[29:2], DATAI[31:16]};

   // Decode the access type and target register.
   always_comb begin
      reg_sel  = ADDR[1:0];
      rd_en    = CE & (WSTB == 4'b0000);
      wr_en    = CE & (WSTB != 4'b0000);
      push_req = wr_en & (reg_sel == REG_TXDATA) & WSTB[0];
      ovf_clr  = wr_en & (reg_sel == REG_STATUS) & WSTB[0] & DATAI[ST_OVF];
      baud_wr  = wr_en & (reg_sel == REG_BAUDDIV);
   end

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST),
      .push_i  (push_req),
      .wdata_i (DATAI[BYTE_W-1:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Sticky overflow flag and byte-lane BAUDDIV updates.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ovf_q  <= 1'b0;
         baud_q <= DEFAULT_DIV;
      end else begin
         if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
         if (baud_wr && WSTB[0]) baud_q[7:0]  <= DATAI[7:0];
         if (baud_wr && WSTB[1]) baud_q[15:8] <= DATAI[15:8];
      end
   end

`ifdef MMIO_UART_IRQ_EN
   // Interrupt enable and registered "transmitter drained" interrupt.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         irqen_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_en && (reg_sel == REG_IRQEN) && WSTB[0]) irqen_q <= DATAI[0];
         irq_q <= irqen_q & fifo_empty & (state_q == TX_IDLE);
      end
   end

   assign IRQ = irq_q;
`endif

   // Assemble read data for the selected register.
   always_comb begin
      status_c         = '0;
      status_c.full    = fifo_full;
      status_c.empty   = fifo_empty;
      status_c.busy    = (state_q != TX_IDLE);
      status_c.ovf     = ovf_q;
      status_c.count   = ST_COUNT_W'(fifo_count);
      rdata_c          = 32'd0;
      case (reg_sel)
         REG_TXDATA:  rdata_c = 32'd0;
         REG_STATUS:  rdata_c = status_c;
         REG_BAUDDIV: rdata_c = {16'd0, baud_q};
`ifdef MMIO_UART_IRQ_EN
         REG_IRQEN:   rdata_c = {31'd0, irqen_q};
`else
         REG_IRQEN:   rdata_c = 32'd0;
`endif
         default:     rdata_c = 32'd0;
      endcase
   end

   // Read data register; holds between reads.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         datao_q <= 32'd0;
      end else if (rd_en) begin
         datao_q <= rdata_c;
      end
   end

   assign DATAO = datao_q;

   // TX engine state register; reset forces the line idle immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= TX_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
      end
   end

   // TX engine next state; TXD is registered as the level of the next cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      txd_d     = txd_q;
      fifo_pop  = 1'b0;

      case (state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_d  = fifo_rdata;
               div_d    = baud_q;
               cnt_d    = baud_q;
               txd_d    = 1'b0;
               state_d  = TX_START;
            end
         end
         TX_START: begin
            if (cnt_q == '0) begin
               cnt_d     = div_q;
               bit_idx_d = 3'd0;
               txd_d     = shreg_q[0];
               state_d   = TX_DATA;
            end else begin
               cnt_d = cnt_q - BAUD_W'(1);
            end
         end
         TX_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = div_q;
               if (bit_idx_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = TX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shreg_d   = {1'b0, shreg_q[BYTE_W-1:1]};
                  txd_d     = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q - BAUD_W'(1);
            end
         end
         TX_STOP: begin
            if (cnt_q == '0) begin
               if (!fifo_empty) begin
                  // Back-to-back frame: no idle gap after the stop bit.
                  fifo_pop = 1'b1;
                  shreg_d  = fifo_rdata;
                  div_d    = baud_q;
                  cnt_d    = baud_q;
                  txd_d    = 1'b0;
                  state_d  = TX_START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = TX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - BAUD_W'(1);
            end
         end
         default: begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
         end
      endcase
   end

   assign TXD = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: the driver predicts frames and register
// reads from a timeline model; a negedge monitor pops and compares them.
module tb_mmio_uart_tx;
   import mmio_pkg::*;

   localparam int DEPTH   = 8;
   localparam int DEF_DIV = 433;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CE  = 1'b0;
   logic [29:0] ADDR  = '0;
   logic [31:0] DATAI = '0;
   logic [3:0]  WSTB  = '0;
   wire  [31:0] DATAO;
   wire         TXD;
`ifdef MMIO_UART_IRQ_EN
   wire         IRQ;
`endif

   mmio_uart_tx #(
      .FIFO_DEPTH  (DEPTH),
      .DEFAULT_DIV (16'(DEF_DIV))
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .CE    (CE),
      .ADDR  (ADDR),
      .DATAI (DATAI),
      .WSTB  (WSTB),
      .DATAO (DATAO),
      .TXD   (TXD)
`ifdef MMIO_UART_IRQ_EN
      ,
      .IRQ   (IRQ)
`endif
   );

   always #5 CLK = ~CLK;

   // Edge counter: after rising edge N, cyc == N.
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         start;
      int         fin;
      int         div;
      logic [7:0] data;
   } frame_t;

   typedef struct {
      int          at_edge;
      int          kind;     // 0: DATAO, 1: IRQ, 2: pre-captured value
      logic [31:0] exp;
      logic [31:0] act;
      string       name;
   } chk_t;

   frame_t mframes[$];   // every accepted byte since reset (model timeline)
   frame_t frame_q[$];   // frames still to be observed on TXD
   chk_t   chk_q[$];

   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] cur_baud;
   bit          ovf_m;
   bit          irqen_m;
   int          last_end;
   int          last_start;
   bit          mon_active = 1'b0;

   // ---------------- model helpers ----------------
   function automatic int count_at(input int r);
      int c = 0;
      foreach (mframes[i]) if (mframes[i].start >= r) c++;
      return c;
   endfunction

   function automatic bit busy_at(input int r);
      foreach (mframes[i])
         if (mframes[i].start <= r - 1 && r - 1 < mframes[i].fin) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] status_exp(input int r);
      int c;
      c = count_at(r);
      return {16'd0, 8'(c), 4'd0, ovf_m, busy_at(r), (c == 0), (c == DEPTH)};
   endfunction

   task automatic model_reset();
      mframes.delete();
      frame_q.delete();
      cur_baud   = 16'(DEF_DIV);
      ovf_m      = 1'b0;
      irqen_m    = 1'b0;
      last_end   = 0;
      last_start = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_op(input logic [1:0] sel, input logic [31:0] d,
                         input logic [3:0] stb, output int e);
      @(negedge CLK);
      ADDR  = {28'd0, sel};
      DATAI = d;
      WSTB  = stb;
      CE    = 1'b1;
      e     = cyc + 1;
      @(posedge CLK);
      #1;
      CE   = 1'b0;
      WSTB = 4'b0000;
   endtask

   task automatic push_byte(input logic [7:0] b);
      int e;
      frame_t f;
      bus_op(REG_TXDATA, {24'd0, b}, 4'b0001, e);
      if (count_at(e) < DEPTH) begin
         f.start = (e + 1 > last_end) ? e + 1 : last_end;
         f.div   = int'(cur_baud);
         f.fin   = f.start + 10 * (f.div + 1);
         f.data  = b;
         mframes.push_back(f);
         frame_q.push_back(f);
         last_end   = f.fin;
         last_start = f.start;
      end else begin
         ovf_m = 1'b1;
      end
   endtask

   task automatic read_reg(input logic [1:0] sel, input string nm, input bit hold);
      int e;
      logic [31:0] exp;
      bus_op(sel, 32'hDEAD_BEEF, 4'b0000, e);
      case (sel)
         REG_STATUS:  exp = status_exp(e);
         REG_BAUDDIV: exp = {16'd0, cur_baud};
`ifdef MMIO_UART_IRQ_EN
         REG_IRQEN:   exp = {31'd0, irqen_m};
`endif
         default:     exp = 32'd0;
      endcase
      chk_q.push_back('{e, 0, exp, 32'd0, nm});
      if (hold) begin
         chk_q.push_back('{e + 3, 0, exp, 32'd0, "datao_hold"});
         repeat (4) @(negedge CLK);
      end
   endtask

   task automatic wait_all_started();
      while (cyc + 1 < last_start) @(negedge CLK);
   endtask

   task automatic write_baud(input logic [15:0] v, input logic [3:0] stb);
      int e;
      wait_all_started();
      bus_op(REG_BAUDDIV, {16'd0, v}, stb, e);
      if (stb[0]) cur_baud[7:0]  = v[7:0];
      if (stb[1]) cur_baud[15:8] = v[15:8];
   endtask

   task automatic write_status(input logic [31:0] d, input logic [3:0] stb);
      int e;
      bus_op(REG_STATUS, d, stb, e);
      if (stb[0] && d[3]) ovf_m = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((frame_q.size() > 0 || mon_active || cyc <= last_end + 1) && n < 20000) begin
         @(negedge CLK);
         n++;
      end
      chk_q.push_back('{cyc, 2, 32'd0, 32'(frame_q.size()), "drain"});
   endtask

`ifdef MMIO_UART_IRQ_EN
   // Predict IRQ after the next rising edge.
   task automatic irq_expect();
      int r;
      r = cyc + 1;
      chk_q.push_back('{r, 1, {31'd0, irqen_m & (count_at(r) == 0) & ~busy_at(r)},
                        32'd0, "irq"});
   endtask
`endif

   // ---------------- monitor ----------------
   task automatic compare(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, a, e, cyc);
      end
   endtask

   initial begin : monitor
      frame_t      f;
      int          pos;
      int          k;
      logic        expb;
      logic [31:0] act;
      pos = 0;
      forever begin
         @(negedge CLK);
         for (int i = 0; i < chk_q.size(); ) begin
            if (chk_q[i].kind == 2 || chk_q[i].at_edge <= cyc) begin
               if (chk_q[i].kind == 0) act = DATAO;
`ifdef MMIO_UART_IRQ_EN
               else if (chk_q[i].kind == 1) act = {31'd0, IRQ};
`endif
               else act = chk_q[i].act;
               compare(chk_q[i].name, act, chk_q[i].exp);
               chk_q.delete(i);
            end else begin
               i++;
            end
         end
         if (!RST) begin
            mon_active = 1'b0;
         end else begin
            if (!mon_active && (TXD == 1'b0 || (frame_q.size() > 0 && cyc >= frame_q[0].start))) begin
               if (frame_q.size() == 0) begin
                  compare("idle_txd", {31'd0, TXD}, 32'd1);
               end else begin
                  f = frame_q.pop_front();
                  compare("start_cycle", 32'(cyc), 32'(f.start));
                  mon_active = 1'b1;
                  pos = 0;
               end
            end
            if (mon_active) begin
               k = pos / (f.div + 1);
               if (k == 0)      expb = 1'b0;
               else if (k == 9) expb = 1'b1;
               else             expb = f.data[k-1];
               compare("txd_bit", {31'd0, TXD}, {31'd0, expb});
               pos++;
               if (pos == 10 * (f.div + 1)) mon_active = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin : driver
      int s0;
      int r;
      model_reset();
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      chk_q.push_back('{cyc + 1, 0, 32'd0, 32'd0, "datao_reset"});
`ifdef MMIO_UART_IRQ_EN
      chk_q.push_back('{cyc + 1, 1, 32'd0, 32'd0, "irq_reset"});
`endif
      @(negedge CLK);
      read_reg(REG_STATUS,  "status_reset", 1'b0);
      read_reg(REG_BAUDDIV, "baud_reset",   1'b0);
      read_reg(REG_TXDATA,  "txdata_read",  1'b0);
      read_reg(REG_IRQEN,   "reg_c_reset",  1'b1);

      // Single frame 0x55 at BAUDDIV=3.
      write_baud(16'd3, 4'b0011);
      push_byte(8'h55);
      read_reg(REG_STATUS, "status_busy", 1'b0);
      wait_drain();

      // Back-to-back frames.
      push_byte(8'hA5);
      push_byte(8'h3C);
      wait_drain();

      // BAUDDIV change mid-frame applies only to the next frame.
      push_byte(8'h0F);
      write_baud(16'd7, 4'b0001);
      push_byte(8'hC3);
      read_reg(REG_BAUDDIV, "baud_7", 1'b0);
      wait_drain();

      // Overflow at a slow rate, then OVF clear, then reset mid-DATA.
      write_baud(16'd100, 4'b0011);
      push_byte(8'($urandom));
      s0 = last_start;
      repeat (9) push_byte(8'($urandom));
      read_reg(REG_STATUS, "status_full_ovf", 1'b0);
      write_status(32'h0000_0008, 4'b0001);
      read_reg(REG_STATUS, "status_ovf_clr", 1'b1);
      while (cyc < s0 + 3 * 101 + 7) @(negedge CLK);
      #2 RST = 1'b0;
      #1 chk_q.push_back('{cyc, 2, 32'd1, {31'd0, TXD}, "txd_async_reset"});
      model_reset();
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      chk_q.push_back('{cyc + 1, 0, 32'd0, 32'd0, "datao_after_reset"});
      @(negedge CLK);
      read_reg(REG_STATUS,  "status_after_reset", 1'b0);
      read_reg(REG_BAUDDIV, "baud_after_reset",   1'b0);

      // One cycle per bit.
      write_baud(16'd0, 4'b0011);
      push_byte(8'h81);
      push_byte(8'h7E);
      wait_drain();

      // Randomised mix of pushes, reads, gaps and configuration writes.
      for (int it = 0; it < 60; it++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2, 3, 4: push_byte(8'($urandom));
            5: read_reg(REG_STATUS, "status_rand", 1'b0);
            6: repeat (int'($urandom_range(0, 30))) @(negedge CLK);
            7: begin
               if ($urandom_range(0, 1) == 0) write_baud(16'($urandom_range(0, 3)), 4'b0001);
               else write_baud(16'($urandom_range(0, 3)), 4'b0011);
               read_reg(REG_BAUDDIV, "baud_rand", 1'b0);
            end
            8: begin
               int e;
               bus_op(REG_TXDATA, 32'($urandom), 4'b1110, e);
            end
            default: write_status(32'($urandom), 4'($urandom_range(1, 15)));
         endcase
      end
      wait_drain();
      read_reg(REG_STATUS, "status_drained", 1'b0);

`ifdef MMIO_UART_IRQ_EN
      begin
         int e;
         write_baud(16'd3, 4'b0011);
         bus_op(REG_IRQEN, 32'd1, 4'b0001, e);
         irqen_m = 1'b1;
         @(negedge CLK);
         read_reg(REG_IRQEN, "irqen_read", 1'b0);
         repeat (4) begin irq_expect(); @(negedge CLK); end
         irq_expect();
         push_byte(8'h96);
         repeat (50) begin irq_expect(); @(negedge CLK); end
         wait_drain();
      end
`endif

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
